// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction fetch front end with a Depth-entry
// prefetch queue and up to Depth fetches in flight or queued.
// Redirects flush the queue and drop stale in-order responses.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_flushed
// saturating counters.
module fetch_prefetch_unit #(
   parameter int                   DataWidth   = 32,
   parameter int                   Depth       = 4,
   parameter logic [DataWidth-1:0] ResetVector = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 instruc_mem_valid,
   input  logic [DataWidth-1:0] instruction_in,
   output logic                 instruction_mem_request,
   output logic                 instruction_mem_we_re,
   output logic [3:0]           instruc_mask_singal,
   output logic [DataWidth-1:0] pc_address,
   input  logic                 redirect,
   input  logic [DataWidth-1:0] redirect_target,
   input  logic                 stall,
   output logic                 instr_valid,
   output logic [DataWidth-1:0] instruction,
   output logic [DataWidth-1:0] pre_address_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]          perf_fetched,
   output logic [31:0]          perf_flushed
`endif
);

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;

   logic [DataWidth-1:0] fetch_pc;
   logic [DataWidth-1:0] resp_pc;
   logic [CntW-1:0]      count;
   logic [CntW-1:0]      outstanding;
   logic [CntW-1:0]      drop_cnt;
   logic [PtrW-1:0]      wr_ptr;
   logic [PtrW-1:0]      rd_ptr;
   logic [DataWidth-1:0] q_data [Depth];
   logic [DataWidth-1:0] q_pc   [Depth];

   logic                 credit_ok;
   logic                 req;
   logic                 drop_resp;
   logic                 push;
   logic                 pop;
   logic [CntW-1:0]      outstanding_nxt;
   logic [CntW-1:0]      count_nxt;
   logic [CntW-1:0]      drop_nxt;
   logic [DataWidth-1:0] target_aligned;
   logic                 unused_tgt_bits;

   // Credits cover both queued entries and in-flight fetches, so the queue
   // can never overflow regardless of memory latency.
   assign credit_ok       = ({1'b0, count} + {1'b0, outstanding}) < (CntW+1)'(Depth);
   assign req             = rst && credit_ok && !redirect;
   assign drop_resp       = instruc_mem_valid && (redirect || drop_cnt != '0);
   assign push            = instruc_mem_valid && !drop_resp;
   assign instr_valid     = (count != '0);
   assign pop             = instr_valid && !stall;
   assign outstanding_nxt = outstanding + CntW'(req) - CntW'(instruc_mem_valid);
   assign target_aligned  = {redirect_target[DataWidth-1:2], 2'b00};
   assign unused_tgt_bits = ^redirect_target[1:0];

   // Memory interface outputs are qualified by the request.
   assign instruction_mem_request = req;
   assign instruction_mem_we_re   = 1'b0;
   assign instruc_mask_singal     = req ? 4'b1111 : 4'b0000;
   assign pc_address              = req ? fetch_pc : '0;

   // Queue head toward decode; zero when empty.
   assign instruction    = instr_valid ? q_data[rd_ptr] : '0;
   assign pre_address_pc = instr_valid ? q_pc[rd_ptr]   : '0;

   // Next occupancy and drop count; a redirect overrides both.
   always_comb begin
      // NOTE: every output of a combinational block gets a value on every path
      // (defaults first) so no latch is inferred.
      count_nxt = count + CntW'(push) - CntW'(pop);
      drop_nxt  = drop_cnt;
      if (instruc_mem_valid && drop_cnt != '0) begin
         drop_nxt = drop_cnt - CntW'(1);
      end
      if (redirect) begin
         count_nxt = '0;
         drop_nxt  = outstanding_nxt;
      end
   end

   // Control state: PCs, pointers, occupancy and in-flight bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!rst) begin
         fetch_pc    <= ResetVector;
         resp_pc     <= ResetVector;
         count       <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         count       <= count_nxt;
         outstanding <= outstanding_nxt;
         drop_cnt    <= drop_nxt;
         if (redirect) begin
            fetch_pc <= target_aligned;
            resp_pc  <= target_aligned;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end else begin
            if (req) begin
               fetch_pc <= fetch_pc + DataWidth'(4);
            end
            if (push) begin
               wr_ptr  <= wr_ptr + PtrW'(1);
               resp_pc <= resp_pc + DataWidth'(4);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PtrW'(1);
            end
         end
      end
   end

   // Queue storage: written on push only.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; count gates every read, so
      // stale contents are never visible.
      if (push) begin
         q_data[wr_ptr] <= instruction_in;
         q_pc[wr_ptr]   <= resp_pc;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] flushed_inc;
   logic [32:0] flushed_sum;

   // Discarded responses plus queue entries thrown away by a redirect.
   always_comb begin
      flushed_inc = 32'(drop_resp) + (redirect ? (32'(count) - 32'(pop)) : 32'd0);
      flushed_sum = {1'b0, perf_flushed} + {1'b0, flushed_inc};
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         if (pop && perf_fetched != '1) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
      end
   end
`else
   // Performance counters not built.
`endif

`ifndef SYNTHESIS
   // A response with nothing in flight is illegal stimulus from memory.
   a_resp_has_request: assert property (@(posedge clk) disable iff (!rst)
      instruc_mem_valid |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: table-driven cycle vectors against a bench-side
// in-order instruction memory with configurable latency.
module tb_fetch_prefetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instruc_mem_valid;
   logic [31:0] instruction_in;
   logic        instruction_mem_request;
   logic        instruction_mem_we_re;
   logic [3:0]  instruc_mask_singal;
   logic [31:0] pc_address;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        stall = 1'b0;
   logic        instr_valid;
   logic [31:0] instruction;
   logic [31:0] pre_address_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushed;
`endif

   fetch_prefetch_unit #(.DataWidth(32), .Depth(4), .ResetVector(32'h0)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .instruc_mem_valid       (instruc_mem_valid),
      .instruction_in          (instruction_in),
      .instruction_mem_request (instruction_mem_request),
      .instruction_mem_we_re   (instruction_mem_we_re),
      .instruc_mask_singal     (instruc_mask_singal),
      .pc_address              (pc_address),
      .redirect                (redirect),
      .redirect_target         (redirect_target),
      .stall                   (stall),
      .instr_valid             (instr_valid),
      .instruction             (instruction),
      .pre_address_pc          (pre_address_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched            (perf_fetched),
      .perf_flushed            (perf_flushed)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] target;
      logic        exp_req;
      logic [31:0] exp_pc;
      logic        exp_valid;
      logic [31:0] exp_head;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   vec_t  tbl[$];
   pend_t pq[$];
   int    total = 0;
   int    bad = 0;
   int    mem_lat = 1;
   int    cyc = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic add_vec(input logic s, input logic r, input logic [31:0] t,
                          input logic er, input logic [31:0] ep,
                          input logic ev, input logic [31:0] eh);
      vec_t v;
      v = '{s, r, t, er, ep, ev, eh};
      tbl.push_back(v);
   endtask

   // In-order memory: requests sampled mid-cycle, responses driven after the edge.
   initial begin
      pend_t p;
      instruc_mem_valid = 1'b0;
      instruction_in    = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (rst && pq.size() > 0 && pq[0].due <= cyc) begin
            instruc_mem_valid = 1'b1;
            instruction_in    = mem_word(pq[0].addr);
            void'(pq.pop_front());
         end else begin
            instruc_mem_valid = 1'b0;
            instruction_in    = '0;
         end
         @(negedge clk);
         if (!rst) begin
            pq.delete();
         end else if (instruction_mem_request) begin
            p.addr = pc_address;
            p.due  = cyc + mem_lat;
            pq.push_back(p);
         end
      end
   end

   // Assert reset (possibly mid-run), check cleared outputs, release on the grid.
   task automatic do_reset(input int lat);
      rst             = 1'b0;
      stall           = 1'b0;
      redirect        = 1'b0;
      redirect_target = '0;
      mem_lat         = lat;
      #1;
      check("rst_req",   32'(instruction_mem_request), 32'h0);
      check("rst_pc",    pc_address, 32'h0);
      check("rst_mask",  32'(instruc_mask_singal), 32'h0);
      check("rst_we",    32'(instruction_mem_we_re), 32'h0);
      check("rst_valid", 32'(instr_valid), 32'h0);
      check("rst_instr", instruction, 32'h0);
      check("rst_hpc",   pre_address_pc, 32'h0);
`ifdef FETCH_PERF_EN
      check("rst_pfetch", perf_fetched, 32'h0);
      check("rst_pflush", perf_flushed, 32'h0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic run_vectors(input int first, input int n);
      for (int i = first; i < first + n; i++) begin
         stall           = tbl[i].stall;
         redirect        = tbl[i].redirect;
         redirect_target = tbl[i].target;
         @(negedge clk);
         check($sformatf("v%0d_req", i), 32'(instruction_mem_request), 32'(tbl[i].exp_req));
         check($sformatf("v%0d_pc", i), pc_address, tbl[i].exp_req ? tbl[i].exp_pc : 32'h0);
         check($sformatf("v%0d_mask", i), 32'(instruc_mask_singal),
               tbl[i].exp_req ? 32'hF : 32'h0);
         check($sformatf("v%0d_we", i), 32'(instruction_mem_we_re), 32'h0);
         check($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
         check($sformatf("v%0d_hpc", i), pre_address_pc,
               tbl[i].exp_valid ? tbl[i].exp_head : 32'h0);
         check($sformatf("v%0d_instr", i), instruction,
               tbl[i].exp_valid ? mem_word(tbl[i].exp_head) : 32'h0);
         @(posedge clk);
         #1;
      end
      stall    = 1'b0;
      redirect = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int s_stall, s_red1, s_red2, s_same, s_perf;

      // Stall fill/drain, 1-cycle memory, stall held cycles 5..14.
      s_stall = tbl.size();
      add_vec(0, 0, 0, 1, 32'h0, 0, 0);
      add_vec(0, 0, 0, 1, 32'h4, 0, 0);
      for (int k = 2; k <= 4; k++) add_vec(0, 0, 0, 1, 32'(4*k), 1, 32'(4*(k-2)));
      add_vec(1, 0, 0, 1, 32'h14, 1, 32'hC);
      add_vec(1, 0, 0, 1, 32'h18, 1, 32'hC);
      for (int k = 7; k <= 14; k++) add_vec(1, 0, 0, 0, 0, 1, 32'hC);
      add_vec(0, 0, 0, 0, 0, 1, 32'hC);
      for (int k = 16; k <= 20; k++)
         add_vec(0, 0, 0, 1, 32'h1C + 32'(4*(k-16)), 1, 32'h10 + 32'(4*(k-16)));

      // 3-cycle memory, redirect to 0x103 with three fetches in flight.
      s_red1 = tbl.size();
      add_vec(0, 0, 0, 1, 32'h0, 0, 0);
      add_vec(0, 0, 0, 1, 32'h4, 0, 0);
      add_vec(0, 0, 0, 1, 32'h8, 0, 0);
      add_vec(0, 1, 32'h103, 0, 0, 0, 0);
      add_vec(0, 0, 0, 1, 32'h100, 0, 0);
      add_vec(0, 0, 0, 1, 32'h104, 0, 0);
      add_vec(0, 0, 0, 1, 32'h108, 0, 0);
      add_vec(0, 0, 0, 1, 32'h10C, 0, 0);
      add_vec(0, 0, 0, 0, 0, 1, 32'h100);
      add_vec(0, 0, 0, 1, 32'h110, 1, 32'h104);
      add_vec(0, 0, 0, 1, 32'h114, 1, 32'h108);

      // 3-cycle memory, second redirect to 0x200 while two responses are pending drop.
      s_red2 = tbl.size();
      add_vec(0, 0, 0, 1, 32'h0, 0, 0);
      add_vec(0, 0, 0, 1, 32'h4, 0, 0);
      add_vec(0, 0, 0, 1, 32'h8, 0, 0);
      add_vec(0, 1, 32'h100, 0, 0, 0, 0);
      add_vec(0, 1, 32'h200, 0, 0, 0, 0);
      add_vec(0, 0, 0, 1, 32'h200, 0, 0);
      add_vec(0, 0, 0, 1, 32'h204, 0, 0);
      add_vec(0, 0, 0, 1, 32'h208, 0, 0);
      add_vec(0, 0, 0, 1, 32'h20C, 0, 0);
      add_vec(0, 0, 0, 0, 0, 1, 32'h200);
      add_vec(0, 0, 0, 1, 32'h210, 1, 32'h204);
      add_vec(0, 0, 0, 1, 32'h214, 1, 32'h208);
      add_vec(0, 0, 0, 1, 32'h218, 1, 32'h20C);

      // 1-cycle memory, redirect coinciding with a response and a pop.
      s_same = tbl.size();
      add_vec(0, 0, 0, 1, 32'h0, 0, 0);
      add_vec(0, 0, 0, 1, 32'h4, 0, 0);
      for (int k = 2; k <= 4; k++) add_vec(0, 0, 0, 1, 32'(4*k), 1, 32'(4*(k-2)));
      add_vec(0, 1, 32'h300, 0, 0, 1, 32'hC);
      add_vec(0, 0, 0, 1, 32'h300, 0, 0);
      add_vec(0, 0, 0, 1, 32'h304, 0, 0);
      add_vec(0, 0, 0, 1, 32'h308, 1, 32'h300);
      add_vec(0, 0, 0, 1, 32'h30C, 1, 32'h304);

      // 20 pops, then a stalled redirect flushing 2 queued entries and 1 response.
      s_perf = tbl.size();
      add_vec(0, 0, 0, 1, 32'h0, 0, 0);
      add_vec(0, 0, 0, 1, 32'h4, 0, 0);
      for (int k = 2; k <= 21; k++) add_vec(0, 0, 0, 1, 32'(4*k), 1, 32'(4*(k-2)));
      add_vec(1, 0, 0, 1, 32'h58, 1, 32'h50);
      add_vec(1, 1, 32'h402, 0, 0, 1, 32'h50);
      add_vec(0, 0, 0, 1, 32'h400, 0, 0);
      add_vec(0, 0, 0, 1, 32'h404, 0, 0);

      @(posedge clk);
      #1;
      do_reset(1);
      run_vectors(s_stall, s_red1 - s_stall);
      // Reset lands mid-operation with a fetch in flight and a full pipeline.
      do_reset(1);
      run_vectors(s_stall, 4);
      do_reset(3);
      run_vectors(s_red1, s_red2 - s_red1);
      do_reset(3);
      run_vectors(s_red2, s_same - s_red2);
      do_reset(1);
      run_vectors(s_same, s_perf - s_same);
      do_reset(1);
      run_vectors(s_perf, tbl.size() - s_perf);
`ifdef FETCH_PERF_EN
      check("perf_fetched", perf_fetched, 32'd20);
      check("perf_flushed", perf_flushed, 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised instruction fetch front end with a multi-entry prefetch queue and multiple in-flight memory requests.
- Replaces the single-instruction fetch stage. Sits between instruction memory and decode.
- Keeps up to Depth fetches in flight or queued.
- Handles branch/jalr redirects by flushing the queue and discarding stale responses in order.

Parameters:
DataWidth, 32, instruction/address width
Depth, 4, prefetch queue entries and maximum in-flight plus queued fetches (power of 2, >=2)
ResetVector, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-low reset
instruc_mem_valid  input  1  response valid; responses return in request order, latency >=1 cycle
instruction_in  input  DataWidth  response data from instruction memory
instruction_mem_request  output  1  fetch request; accepted in the same cycle it is high
instruction_mem_we_re  output  1  constant 0 (read)
instruc_mask_singal  output  4  constant 4'b1111 while requesting, 0 otherwise
pc_address  output  DataWidth  fetch address qualified by request
redirect  input  1  branch taken or jalr resolved in execute
redirect_target  input  DataWidth  new PC; bits [1:0] forced to 0
stall  input  1  decode cannot accept (load-use or memory wait)
instr_valid  output  1  queue head valid toward decode
instruction  output  DataWidth  queue head instruction
pre_address_pc  output  DataWidth  PC of queue head

Behaviour:
- Reset (rst=0, async): fetch_pc=ResetVector, queue empty, outstanding=0, drop_cnt=0. All outputs 0 except the constant we_re=0.
- Credits: request is high when (count + outstanding) < Depth, not redirect, and out of reset. outstanding counts every in-flight request, including those marked for drop.
- Issue: pc_address=fetch_pc while request is high. On issue, fetch_pc += 4 and outstanding += 1.
- Response (instruc_mem_valid=1): outstanding -= 1.
  - If drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise: push {instruction_in, pc} into the queue tail. The pc comes from an internal response-PC register that starts at the issue PC and advances by 4 per kept response.
- Response arriving with outstanding==0 is an illegal stimulus. Assertion only; no recovery.
- Pop: instr_valid && !stall removes the head in the same cycle. The next head is visible the following cycle.
- Push and pop in the same cycle: count is unchanged.
- Full queue: credits are exhausted, so no request is issued. Push cannot overflow by construction.
- Queue wraps at Depth via pointer modulo arithmetic.
- Redirect (highest priority, same cycle):
  - Queue flushed; instr_valid=0 next cycle.
  - drop_cnt <= outstanding_after_this_cycle. A response arriving in the redirect cycle is itself discarded.
  - fetch_pc and response-PC <= {redirect_target[DataWidth-1:2],2'b00}.
  - No request in the redirect cycle. Issue resumes the next cycle, even with drop_cnt>0.
- Redirect during drop: drop_cnt is overwritten with the new total outstanding. Ordering still guarantees correctness.
- Stall held: queue fills to Depth, then requests stop. Head data is held stable.
- Latency: with 1-cycle memory, first instr_valid appears 2 cycles after reset release. Steady state sustains 1 instruction/cycle when Depth>=2.
- Reset mid-operation: all state cleared immediately. Responses to pre-reset requests must not be delivered by memory; the memory is reset by the same rst.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports perf_fetched (32 bits) and perf_flushed (32 bits).
  - perf_fetched counts pops.
  - perf_flushed counts discarded responses plus queue entries flushed by redirect.
  - Both reset to 0 and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release with 1-cycle memory returning PC-as-data, no stall -> requests at 0x0,0x4,0x8...; instr_valid from cycle 2; pre_address_pc 0x0,0x4,0x8 with matching data.
- Stall held 10 cycles, Depth=4 -> exactly 4 entries queued, request low after credits exhausted. Release stall -> 4 consecutive pops with no gap before refill.
- 3-cycle memory latency, redirect to 0x103 while 3 requests are in flight -> next request address 0x100. Three stale responses are discarded; first delivered pre_address_pc is 0x100.
- Redirect in the same cycle as a response and a pop -> response discarded, instr_valid=0 next cycle, no duplicate or lost instruction after restart.
- Second redirect (to 0x200) while drop_cnt=2 -> only 0x200-stream instructions delivered; none from the first target.
- FETCH_PERF_EN build, 20 pops and one redirect flushing 2 queued entries plus 1 in-flight response -> perf_fetched=20, perf_flushed=3.
